// File: rtl/mem_port_arbiter.sv
// Arbitrates the main-memory port between the I-cache and D-cache miss controllers and
// sequences whole-line transfers. Define ARB_ROUND_ROBIN_EN to alternate grants on ties.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_WORDS  = 4,
  parameter int IDX_W       = 2,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_grant,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_word_valid,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_grant,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_word_valid,
  output logic                 d_done,
  output logic [IDX_W-1:0]     xfer_idx,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  // state | meaning
  // IDLE  | port free, arbitrating requests
  // BUSY  | owner's line moving word by word
  // DONE  | owner done held until its req drops
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);

  state_t                      state_q;
  logic                        owner_d_q;
  logic [WORD_SIZE-IDX_W-1:0]  base_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [IDX_W-1:0]            xfer_idx_q;
  logic                        i_grant_q, d_grant_q;
  logic [WORD_SIZE-1:0]        i_rdata_q, d_rdata_q;
  logic                        i_valid_q, d_valid_q;
  logic                        i_done_q, d_done_q;
  logic                        mem_en_q, mem_we_q;
  logic                        pick_d;
  logic                        unused_addr_lsbs;

  // Word offset within the line comes from xfer_idx, never from the request address.
  assign unused_addr_lsbs = ^{i_addr[IDX_W-1:0], d_addr[IDX_W-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;

  assign pick_d = d_req & ~(i_req & last_d_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_d_q <= 1'b0;
    end else if (state_q == IDLE && (d_req || i_req)) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_d_q  <= 1'b0;
      base_q     <= '0;
      cnt_q      <= '0;
      xfer_idx_q <= '0;
      i_grant_q  <= 1'b0;
      d_grant_q  <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_req || i_req) begin
            state_q    <= BUSY;
            owner_d_q  <= pick_d;
            base_q     <= pick_d ? d_addr[WORD_SIZE-1:IDX_W] : i_addr[WORD_SIZE-1:IDX_W];
            mem_we_q   <= pick_d & d_we;
            mem_en_q   <= 1'b1;
            cnt_q      <= '0;
            xfer_idx_q <= '0;
            d_grant_q  <= pick_d;
            i_grant_q  <= ~pick_d;
          end
        end
        BUSY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (!mem_we_q) begin
              if (owner_d_q) begin
                d_rdata_q <= mem_rdata;
                d_valid_q <= 1'b1;
              end else begin
                i_rdata_q <= mem_rdata;
                i_valid_q <= 1'b1;
              end
            end
            if (xfer_idx_q == IDX_LAST) begin
              state_q    <= DONE;
              xfer_idx_q <= '0;
              mem_en_q   <= 1'b0;
              mem_we_q   <= 1'b0;
              d_done_q   <= owner_d_q;
              i_done_q   <= ~owner_d_q;
            end else begin
              xfer_idx_q <= xfer_idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (!(owner_d_q ? d_req : i_req)) begin
            state_q   <= IDLE;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_grant      = i_grant_q;
  assign d_grant      = d_grant_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_word_valid = i_valid_q;
  assign d_word_valid = d_valid_q;
  assign i_done       = i_done_q;
  assign d_done       = d_done_q;
  assign xfer_idx     = xfer_idx_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_en_q ? {base_q, xfer_idx_q} : '0;
  // Write data is a pass-through so the D-cache can index its line by xfer_idx.
  assign mem_wdata    = mem_we_q ? d_wdata : '0;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: line fills, write-back, tie-breaks, reset abort,
// DONE hold. Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_word_valid, i_done;
  logic        d_grant, d_word_valid, d_done;
  logic [15:0] i_rdata, d_rdata;
  logic [1:0]  xfer_idx;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

`ifdef ARB_ROUND_ROBIN_EN
  bit exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
  bit exp_d [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

  logic [15:0] fill_rd [4] = '{16'hBE10, 16'hBE11, 16'hBE12, 16'hBE13};

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rdata(i_rdata),
    .i_word_valid(i_word_valid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_rdata(d_rdata), .d_word_valid(d_word_valid), .d_done(d_done),
    .xfer_idx(xfer_idx), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency memory: data only valid in the 2nd cycle an address is held.
  logic [15:0] prev_addr_q;
  logic        prev_en_q = 1'b0;
  int          prev_cnt_q = 0;
  int          cur_cnt;
  assign cur_cnt   = (mem_en && prev_en_q && mem_addr == prev_addr_q) ? prev_cnt_q + 1 : 0;
  assign mem_rdata = (mem_en && cur_cnt == 1) ? (16'hBE00 ^ mem_addr) : 16'hDEAD;
  always @(posedge clk) begin
    prev_addr_q <= mem_addr;
    prev_en_q   <= mem_en;
    prev_cnt_q  <= cur_cnt;
  end

  assign d_wdata = 16'hA000 + {14'b0, xfer_idx};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit on_d, input string tag);
    int n = 0;
    while (!(on_d ? d_done : i_done) && n < 20) begin
      tick();
      n++;
    end
    check(tag, on_d ? d_done : i_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check("rst busy", busy, 0);
    check("rst i_grant", i_grant, 0);
    check("rst d_grant", d_grant, 0);
    check("rst mem_en", mem_en, 0);
    check("rst xfer_idx", xfer_idx, 0);
    check("rst i_rdata", i_rdata, 0);
    check("rst d_done", d_done, 0);
    reset_n = 1'b1;
    tick();

    // I fill from 0x0013: words 0x10..0x13, two cycles each; done in the 9th granted cycle
    i_req = 1'b1; i_addr = 16'h0013;
    tick();
    check("fill we", mem_we, 0);
    check("fill wdata", mem_wdata, 0);
    for (int k = 0; k <= 8; k++) begin
      if (k == 1) i_addr = 16'h00F0;
      check("fill i_grant", i_grant, 1);
      check("fill d_grant", d_grant, 0);
      check("fill mem_en", mem_en, (k < 8) ? 1 : 0);
      if (k < 8) begin
        check("fill mem_addr", mem_addr, 16'h0010 + k / 2);
        check("fill xfer_idx", xfer_idx, k / 2);
      end
      check("fill valid", i_word_valid, (k >= 2 && k % 2 == 0) ? 1 : 0);
      if (k >= 2 && k % 2 == 0) check("fill rdata", i_rdata, fill_rd[k / 2 - 1]);
      check("fill i_done", i_done, (k == 8) ? 1 : 0);
      if (k < 8) tick();
    end
    tick();
    check("fill valid after done", i_word_valid, 0);
    i_req = 1'b0;
    tick();
    check("fill idle busy", busy, 0);
    check("fill idle i_done", i_done, 0);

    // Simultaneous requests: D first, I after D drops plus one IDLE cycle
    d_we = 1'b0; d_addr = 16'h0020; i_addr = 16'h0031;
    d_req = 1'b1; i_req = 1'b1;
    tick();
    check("tie d_grant", d_grant, 1);
    check("tie i_grant", i_grant, 0);
    check("tie mem_addr", mem_addr, 16'h0020);
    wait_done(1'b1, "tie d_done");
    check("tie last d_rdata", d_rdata, 16'hBE23);
    check("tie last d_valid", d_word_valid, 1);
    check("tie i held off", i_grant, 0);
    d_req = 1'b0;
    tick();
    check("tie gap busy", busy, 0);
    check("tie gap i_grant", i_grant, 0);
    tick();
    check("tie i_grant", i_grant, 1);
    check("tie i mem_addr", mem_addr, 16'h0030);
    wait_done(1'b0, "tie i_done");
    check("tie last i_rdata", i_rdata, 16'hBE33);
    i_req = 1'b0;
    tick();

    // D write-back of 0x0040..0x0043
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040;
    tick();
    for (int k = 0; k <= 8; k++) begin
      check("wb d_valid", d_word_valid, 0);
      if (k < 8) begin
        check("wb mem_we", mem_we, 1);
        check("wb mem_addr", mem_addr, 16'h0040 + k / 2);
        check("wb mem_wdata", mem_wdata, 16'hA000 + k / 2);
        tick();
      end
    end
    check("wb d_done", d_done, 1);
    check("wb mem_en", mem_en, 0);
    check("wb wdata off", mem_wdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Reset while xfer_idx == 2 aborts the transfer
    i_req = 1'b1; i_addr = 16'h0050;
    tick();
    for (int k = 0; k < 4; k++) tick();
    check("abort pre idx", xfer_idx, 2);
    reset_n = 1'b0;
    tick();
    check("abort busy", busy, 0);
    check("abort i_grant", i_grant, 0);
    check("abort mem_en", mem_en, 0);
    check("abort xfer_idx", xfer_idx, 0);
    check("abort i_done", i_done, 0);
    check("abort i_rdata", i_rdata, 0);
    check("abort mem_addr", mem_addr, 0);
    tick();
    check("abort held valid", i_word_valid, 0);
    reset_n = 1'b1;
    tick();
    check("restart i_grant", i_grant, 1);
    check("restart xfer_idx", xfer_idx, 0);
    check("restart mem_addr", mem_addr, 16'h0050);
    wait_done(1'b0, "restart i_done");
    i_req = 1'b0;
    tick();

    // Back-to-back ties, both requests reasserted right after each done
    d_addr = 16'h0060; i_addr = 16'h0068;
    d_req = 1'b1; i_req = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      check("order d_grant", d_grant, exp_d[r]);
      check("order i_grant", i_grant, !exp_d[r]);
      wait_done(exp_d[r], "order done");
      if (exp_d[r]) d_req = 1'b0; else i_req = 1'b0;
      tick();
      check("order gap busy", busy, 0);
      d_req = 1'b1; i_req = 1'b1;
      tick();
    end
    check("order final d_grant", d_grant, 1);
    wait_done(1'b1, "order final done");
    d_req = 1'b0; i_req = 1'b0;
    tick();

    // Owner holds req three cycles past done; I waits throughout
    d_addr = 16'h0070; d_req = 1'b1;
    tick();
    check("hold d_grant", d_grant, 1);
    i_req = 1'b1;
    wait_done(1'b1, "hold d_done");
    for (int h = 0; h < 3; h++) begin
      check("hold d_done", d_done, 1);
      check("hold d_grant", d_grant, 1);
      check("hold mem_en", mem_en, 0);
      check("hold xfer_idx", xfer_idx, 0);
      check("hold i_grant", i_grant, 0);
      if (h < 2) tick();
    end
    d_req = 1'b0;
    tick();
    check("hold release d_done", d_done, 0);
    check("hold release i_grant", i_grant, 0);
    tick();
    check("hold i_grant", i_grant, 1);
    wait_done(1'b0, "hold i_done");
    i_req = 1'b0;
    tick();
    check("end busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
